sonar_uc: RTL

- Moore control unit that sequences the sonar datapath: servo positioning, distance measurement, and 8-character UART frame transmission per position.
- Drives the datapath's zera/conta/medir/partida strobes.
- Consumes the datapath's pronto_medida, pronto_serial, fim_timer and fim_transmissao status signals.
- Adds a measurement watchdog so a missing echo cannot stall the sweep.

---
 rtl/sonar_uc.sv | 134 +++++++++++++
 1 files changed

// File: rtl/sonar_uc.sv
`default_nettype none
// ============================================================================
//  Module      : sonar_uc
//  Description : Moore control unit sequencing servo positioning, distance
//                measurement and 8-character UART frames, with a measurement
//                watchdog so a missing echo cannot stall the sweep.
//  Revision    : 1.0 - initial release
// ============================================================================
module sonar_uc #(
    parameter int TIMEOUT_MEDIDA = 2_000_000,
    parameter int TW             = 22
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    input  logic       pronto_medida,
    input  logic       pronto_serial,
    input  logic       fim_timer,
    input  logic       fim_transmissao,
    output logic       zera_timer,
    output logic       conta_timer,
    output logic       zera_posicao,
    output logic       conta_posicao,
    output logic       reset_servo,
    output logic       medir,
    output logic       zera_serial,
    output logic       conta_serial,
    output logic       partida_serial,
    output logic       timeout_medida,
    output logic [3:0] db_estado
);

    localparam logic [3:0] c_INICIAL        = 4'h0;
    localparam logic [3:0] c_PREPARACAO     = 4'h1;
    localparam logic [3:0] c_ESPERA         = 4'h2;
    localparam logic [3:0] c_MEDE           = 4'h3;
    localparam logic [3:0] c_AGUARDA_MEDIDA = 4'h4;
    localparam logic [3:0] c_TRANSMITE      = 4'h5;
    localparam logic [3:0] c_AGUARDA_TX     = 4'h6;
    localparam logic [3:0] c_PROXIMO_CHAR   = 4'h7;
    localparam logic [3:0] c_VERIFICA_FIM   = 4'h8;
    localparam logic [3:0] c_MOVE_SERVO     = 4'h9;

    localparam logic [TW-1:0] c_WD_LIMIT = TW'(TIMEOUT_MEDIDA - 1);
    localparam logic [TW-1:0] c_WD_MAX   = '1;

    logic [3:0]    r_estado;
    logic [3:0]    w_proximo;
    logic [TW-1:0] r_watchdog;
    logic          r_timeout;
    logic          w_wd_fim;

    assign w_wd_fim = (r_watchdog == c_WD_LIMIT);

    always_comb begin
        w_proximo = c_INICIAL;
        case (r_estado)
            c_INICIAL:        w_proximo = ligar ? c_PREPARACAO : c_INICIAL;
            c_PREPARACAO:     w_proximo = c_ESPERA;
            c_ESPERA:         w_proximo = fim_timer ? c_MEDE : c_ESPERA;
            c_MEDE:           w_proximo = c_AGUARDA_MEDIDA;
            c_AGUARDA_MEDIDA: w_proximo = (pronto_medida || w_wd_fim) ? c_TRANSMITE : c_AGUARDA_MEDIDA;
            c_TRANSMITE:      w_proximo = c_AGUARDA_TX;
            c_AGUARDA_TX:     w_proximo = pronto_serial ? c_PROXIMO_CHAR : c_AGUARDA_TX;
            c_PROXIMO_CHAR:   w_proximo = c_VERIFICA_FIM;
            c_VERIFICA_FIM: begin
                if (!fim_transmissao)
                    w_proximo = c_TRANSMITE;
                else if (ligar)
                    w_proximo = c_MOVE_SERVO;
                else
                    w_proximo = c_INICIAL;
            end
            c_MOVE_SERVO:     w_proximo = c_ESPERA;
            default:          w_proximo = c_INICIAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado   <= c_INICIAL;
            r_watchdog <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_estado <= w_proximo;
            if (r_estado == c_MEDE) begin
                r_watchdog <= '0;
            end else if (r_estado == c_AGUARDA_MEDIDA && r_watchdog != c_WD_MAX) begin
                r_watchdog <= r_watchdog + 1'b1;
            end
            // A measurement arriving on the deadline cycle still counts as good
            if (r_estado == c_PREPARACAO) begin
                r_timeout <= 1'b0;
            end else if (r_estado == c_AGUARDA_MEDIDA && !pronto_medida && w_wd_fim) begin
                r_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        zera_timer     = 1'b0;
        conta_timer    = 1'b0;
        zera_posicao   = 1'b0;
        conta_posicao  = 1'b0;
        reset_servo    = 1'b0;
        medir          = 1'b0;
        zera_serial    = 1'b0;
        conta_serial   = 1'b0;
        partida_serial = 1'b0;
        case (r_estado)
            c_PREPARACAO: begin
                zera_timer   = 1'b1;
                zera_posicao = 1'b1;
                zera_serial  = 1'b1;
                reset_servo  = 1'b1;
            end
            c_ESPERA:       conta_timer    = 1'b1;
            c_MEDE:         medir          = 1'b1;
            c_TRANSMITE:    partida_serial = 1'b1;
            c_PROXIMO_CHAR: conta_serial   = 1'b1;
            c_MOVE_SERVO: begin
                conta_posicao = 1'b1;
                zera_timer    = 1'b1;
                zera_serial   = 1'b1;
            end
            default: ;
        endcase
    end

    assign timeout_medida = r_timeout;
    assign db_estado      = r_estado;

endmodule
`default_nettype wire
